sonic_pcs_pg_burst_ctrl: RTL and testbench

Sequencer for the PCS pattern-generator symbol stream. It produces bursts of 2-bit Avalon-ST symbols (fixed, PRBS7, counter or alternating pattern), separated by programmable idle gaps, for a programmable number of bursts. It honours downstream ready so the timing adapter never sees an unbackpressurable source. It sits between the pattern-generator CSRs and the pre-timing-adapter stream port.

---
 rtl/sonic_pcs_pg_pkg.sv | 27 ++
 rtl/sonic_pcs_pg_symbol_gen.sv | 50 +++++
 rtl/sonic_pcs_pg_burst_ctrl.sv | 156 +++++++++++++++
 tb/tb_sonic_pcs_pg_burst_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pcs_pg_pkg.sv
// Shared definitions for the PCS pattern-generator burst sequencer:
// controller states, pattern-mode encodings, symbol width and the PRBS7 step.
package sonic_pcs_pg_pkg;

    localparam int         SYM_W             = 2;
    localparam logic [6:0] PRBS_SEED_DEFAULT = 7'h7F;

    localparam logic [1:0] PG_FIXED = 2'b00;
    localparam logic [1:0] PG_PRBS7 = 2'b01;
    localparam logic [1:0] PG_CNT   = 2'b10;
    localparam logic [1:0] PG_ALT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } pg_state_e;

    // Two shifts of the x^7+x^6+1 LFSR: one 2-bit symbol worth of sequence.
    function automatic logic [6:0] prbs7_step2(input logic [6:0] l);
        logic [6:0] t;
        t = {l[5:0], l[6] ^ l[5]};
        return {t[5:0], t[6] ^ t[5]};
    endfunction

endpackage

// File: rtl/sonic_pcs_pg_symbol_gen.sv
// Mode-selected symbol source. All sources step together on advance; the
// output mux picks the one for the run's registered mode.
module sonic_pcs_pg_symbol_gen
    import sonic_pcs_pg_pkg::*;
#(
    parameter logic [6:0] PRBS_SEED = PRBS_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reload,
    input  logic             advance,
    input  logic [1:0]       mode,
    input  logic [SYM_W-1:0] pattern,
    output logic [SYM_W-1:0] symbol
);

    logic [6:0]       lfsr_q;
    logic [SYM_W-1:0] cnt_q;
    logic [SYM_W-1:0] alt_q;

    // Source state: reload (run start) wins over advance (accepted beat).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= PRBS_SEED;
            cnt_q  <= '0;
            alt_q  <= 2'b01;
        end else if (reload) begin
            lfsr_q <= PRBS_SEED;
            cnt_q  <= '0;
            alt_q  <= 2'b01;
        end else if (advance) begin
            lfsr_q <= prbs7_step2(lfsr_q);
            cnt_q  <= cnt_q + 2'd1;
            alt_q  <= ~alt_q;
        end
    end

    // Output symbol selection by mode.
    always_comb begin
        symbol = pattern;
        case (mode)
            PG_FIXED: symbol = pattern;
            PG_PRBS7: symbol = {lfsr_q[6], lfsr_q[5]};
            PG_CNT:   symbol = cnt_q;
            PG_ALT:   symbol = alt_q;
            default:  symbol = pattern;
        endcase
    end

endmodule

// File: rtl/sonic_pcs_pg_burst_ctrl.sv
// Burst/gap sequencer for the pattern-generator stream. Config is captured on
// an accepted start so mid-run CSR writes cannot disturb the run in progress.
module sonic_pcs_pg_burst_ctrl
    import sonic_pcs_pg_pkg::*;
#(
    parameter int         LEN_W     = 16,
    parameter int         NB_W      = 16,
    parameter int         STALL_W   = 32,
    parameter logic [6:0] PRBS_SEED = PRBS_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_mode,
    input  logic [SYM_W-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_burst_len,
    input  logic [LEN_W-1:0]   cfg_gap_len,
    input  logic [NB_W-1:0]    cfg_num_bursts,
    output logic [SYM_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [NB_W-1:0]    burst_idx,
    output logic [STALL_W-1:0] stall_count
);

    pg_state_e          state_q, state_d;
    logic [1:0]         mode_q;
    logic [SYM_W-1:0]   pattern_q;
    logic [LEN_W-1:0]   len_q, gap_len_q;
    logic [NB_W-1:0]    num_q;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NB_W-1:0]    burst_idx_q, burst_idx_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               start_acc, accept, last_beat, final_burst;
    logic [SYM_W-1:0]   symbol;

    assign start_acc   = (state_q == ST_IDLE) && start && !abort;
    assign out_valid   = (state_q == ST_BURST);
    assign accept      = out_valid && out_ready;
    assign last_beat   = (beat_q == len_q - LEN_W'(1));
    assign final_burst = (num_q != '0) && (burst_idx_q == num_q - NB_W'(1));

    assign out_data    = out_valid ? symbol : '0;
    assign busy        = (state_q == ST_BURST) || (state_q == ST_GAP);
    assign done        = (state_q == ST_DONE);
    assign burst_idx   = burst_idx_q;
    assign stall_count = stall_q;

    // Capture the run configuration; a zero burst length is stored as one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= PG_FIXED;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            gap_len_q <= '0;
            num_q     <= '0;
        end else if (start_acc) begin
            mode_q    <= cfg_mode;
            pattern_q <= cfg_pattern;
            len_q     <= (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;
            gap_len_q <= cfg_gap_len;
            num_q     <= cfg_num_bursts;
        end
    end

    // Controller state and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            burst_idx_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            burst_idx_q <= burst_idx_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        burst_idx_d = burst_idx_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_BURST;
                        beat_d      = '0;
                        burst_idx_d = '0;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        beat_d = beat_q + LEN_W'(1);
                        if (last_beat) begin
                            beat_d = '0;
                            if (final_burst) begin
                                state_d = ST_DONE;
                            end else if (gap_len_q != '0) begin
                                state_d   = ST_GAP;
                                gap_cnt_d = gap_len_q - LEN_W'(1);
                            end else begin
                                burst_idx_d = burst_idx_q + NB_W'(1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d     = ST_BURST;
                        burst_idx_d = burst_idx_q + NB_W'(1);
                    end else begin
                        gap_cnt_d = gap_cnt_q - LEN_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Saturating backpressure counter, cleared by an accepted start.
    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    sonic_pcs_pg_symbol_gen #(
        .PRBS_SEED (PRBS_SEED)
    ) u_symbol_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .reload  (start_acc),
        .advance (accept),
        .mode    (mode_q),
        .pattern (pattern_q),
        .symbol  (symbol)
    );

endmodule

// File: tb/tb_sonic_pcs_pg_burst_ctrl.sv
// Self-checking bench: a reference model expands each run into a queue of
// expected beats (symbol, burst index, following gap) and steps through it
// per cycle using the bench-generated ready, compared against the DUT.
module tb_sonic_pcs_pg_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [1:0]  cfg_pattern = '0;
    logic [15:0] cfg_burst_len = '0;
    logic [15:0] cfg_gap_len = '0;
    logic [15:0] cfg_num_bursts = '0;
    logic [1:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] burst_idx;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sonic_pcs_pg_burst_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_mode       (cfg_mode),
        .cfg_pattern    (cfg_pattern),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_gap_len    (cfg_gap_len),
        .cfg_num_bursts (cfg_num_bursts),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .burst_idx      (burst_idx),
        .stall_count    (stall_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  data;
        logic [15:0] idx;
        int          gap_after;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    int          m_gap_rem = 0;
    logic [15:0] m_last_idx = '0;
    logic [31:0] m_stall = '0;

    // Expand a run into its full beat list from the pattern rules.
    task automatic build_run(input logic [1:0] mode, input logic [1:0] pat,
                             input int len, input int gap, input int nb, input int max_beats);
        int eff, nbursts, total, n;
        bit s[];
        logic [6:0] seed_v;
        beat_t bt;
        seed_v  = 7'h7F;
        eff     = (len == 0) ? 1 : len;
        nbursts = (nb == 0) ? (max_beats + eff - 1) / eff : nb;
        total   = nbursts * eff;
        s = new[2 * total + 8];
        for (int i = 0; i < 7; i++) s[i] = seed_v[6 - i];
        for (int i = 7; i < 2 * total + 8; i++) s[i] = s[i - 7] ^ s[i - 6];
        exp_q.delete();
        for (int b = 0; b < nbursts; b++) begin
            for (int k = 0; k < eff; k++) begin
                n = b * eff + k;
                case (mode)
                    2'b00:   bt.data = pat;
                    2'b01:   bt.data = {s[2 * n], s[2 * n + 1]};
                    2'b10:   bt.data = 2'(n % 4);
                    default: bt.data = (n % 2 == 0) ? 2'b01 : 2'b10;
                endcase
                bt.idx       = 16'(b);
                bt.last      = (nb != 0) && (b == nb - 1) && (k == eff - 1);
                bt.gap_after = ((k == eff - 1) && !bt.last) ? gap : 0;
                exp_q.push_back(bt);
            end
        end
    endtask

    function automatic bit model_valid();
        return m_run && (m_gap_rem == 0) && (exp_q.size() > 0);
    endfunction

    function automatic logic [52:0] model_vec();
        logic [1:0]  d;
        logic [15:0] ix;
        d  = 2'b00;
        ix = m_last_idx;
        if (model_valid()) begin
            d  = exp_q[0].data;
            ix = exp_q[0].idx;
        end
        return {model_valid(), d, m_run, m_done, ix, m_stall};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {out_valid, (out_valid ? out_data : 2'b00), busy, done, burst_idx, stall_count};
    endfunction

    task automatic model_advance(input bit rdy, input bit ab);
        bit v;
        beat_t bt;
        v = model_valid();
        if (v && !rdy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        m_done = 1'b0;
        if (ab) begin
            if (v) m_last_idx = exp_q[0].idx;
            m_run = 1'b0;
            m_gap_rem = 0;
            exp_q.delete();
        end else if (v && rdy) begin
            bt = exp_q.pop_front();
            m_last_idx = bt.idx;
            if (bt.last) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_gap_rem = bt.gap_after;
            end
        end else if (m_run && m_gap_rem > 0) begin
            m_gap_rem--;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run = 1'b0; m_done = 1'b0; m_gap_rem = 0; m_last_idx = '0; m_stall = '0;
    endtask

    // Pulse start for one cycle with the given config (DUT must be idle).
    task automatic do_start(input logic [1:0] mode, input logic [1:0] pat, input int len,
                            input int gap, input int nb, input int max_beats);
        cfg_mode = mode; cfg_pattern = pat; cfg_burst_len = 16'(len);
        cfg_gap_len = 16'(gap); cfg_num_bursts = 16'(nb);
        start = 1'b1;
        model_advance(out_ready, 1'b0);
        build_run(mode, pat, len, gap, nb, max_beats);
        m_run = 1'b1; m_stall = '0; m_last_idx = '0; m_gap_rem = 0; m_done = 1'b0;
        $display("run: mode=%b pat=%b len=%0d gap=%0d nb=%0d", mode, pat, len, gap, nb);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [52:0] a;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = dut_vec(); checks++;
        if (a !== model_vec()) begin errors++; $display("FAIL reset_state: dut=%h model=%h", a, model_vec()); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_start(2'b01, 2'b00, 5, 0, 1, 10);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL reset_prerun cyc %0d: dut=%h model=%h", c, a, model_vec()); end
            model_advance(1'b0, 1'b0);
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        a = dut_vec(); checks++;
        if (a !== model_vec()) begin errors++; $display("FAIL async_reset: dut=%h model=%h", a, model_vec()); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        int cyc; logic [7:0] vpat; logic [52:0] a;
        out_ready = 1'b1;
        do_start(2'b00, 2'b10, 3, 2, 2, 0);
        cyc = 0; vpat = '0;
        while ((m_run || m_done) && cyc < 40) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL fixed cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            if (cyc < 8) vpat = {vpat[6:0], out_valid};
            model_advance(1'b1, 1'b0);
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc >= 40) begin errors++; $display("FAIL fixed_timeout: cycles=%0d limit=40", cyc); end
        checks++;
        if (vpat !== 8'b11100111) begin errors++; $display("FAIL fixed_valid_pattern: got %b want 11100111", vpat); end
    endtask

    task automatic test_prbs();
        int cyc, nacc; logic [7:0] syms; logic [52:0] a; bit rdy;
        do_start(2'b01, 2'b00, 4, $urandom_range(0, 3), 3, 0);
        cyc = 0; nacc = 0; syms = '0;
        while ((m_run || m_done) && cyc < 200) begin
            rdy = ($urandom_range(0, 3) != 0);
            out_ready = rdy;
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL prbs cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            if (out_valid && rdy && nacc < 4) begin syms = {syms[5:0], out_data}; nacc++; end
            model_advance(rdy, 1'b0);
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL prbs_timeout: cycles=%0d limit=200", cyc); end
        checks++;
        if (syms !== 8'b11111110) begin errors++; $display("FAIL prbs_first_beats: got %b want 11111110", syms); end
    endtask

    task automatic test_counter_stall();
        int cyc; logic [11:0] dseq; logic [52:0] a; bit rdy;
        logic [5:0] rpat;
        rpat = 6'b001111;
        out_ready = 1'b0;
        do_start(2'b10, 2'b00, 4, 0, 1, 0);
        cyc = 0; dseq = '0;
        while ((m_run || m_done) && cyc < 30) begin
            rdy = (cyc < 6) ? rpat[5 - cyc] : 1'b1;
            out_ready = rdy;
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL counter cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            if (cyc < 6) dseq = {dseq[9:0], out_data};
            model_advance(rdy, 1'b0);
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (dseq !== 12'b000000011011) begin errors++; $display("FAIL counter_data_seq: got %b want 000000011011", dseq); end
        checks++;
        if (stall_count !== 32'd2) begin errors++; $display("FAIL counter_stall_count: got %0d want 2", stall_count); end
    endtask

    task automatic test_back_to_back();
        int cyc, ndone; logic [5:0] vseq; logic [11:0] iseq; logic [52:0] a;
        out_ready = 1'b1;
        do_start(2'($urandom_range(0, 3)), 2'b01, 2, 0, 3, 0);
        cyc = 0; ndone = 0; vseq = '0; iseq = '0;
        while ((m_run || m_done) && cyc < 30) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL b2b cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            if (cyc < 6) begin vseq = {vseq[4:0], out_valid}; iseq = {iseq[9:0], burst_idx[1:0]}; end
            if (done) ndone++;
            model_advance(1'b1, 1'b0);
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (vseq !== 6'b111111) begin errors++; $display("FAIL b2b_valid: got %b want 111111", vseq); end
        checks++;
        if (iseq !== 12'b000001011010) begin errors++; $display("FAIL b2b_idx: got %b want 000001011010", iseq); end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_abort();
        int cyc; logic [52:0] a; bit rdy; logic [1:0] first_sym;
        do_start(2'b01, 2'b00, $urandom_range(2, 6), $urandom_range(0, 3), 0, 400);
        for (cyc = 0; cyc < 25; cyc++) begin
            rdy = ($urandom_range(0, 1) != 0);
            out_ready = rdy;
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL abort_run cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            model_advance(rdy, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (cyc = 0; cyc < 20 && !model_valid(); cyc++) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL abort_wait cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            model_advance(1'b0, 1'b0);
            @(posedge clk); #1;
        end
        model_advance(1'b0, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        a = dut_vec(); checks++;
        if (a !== model_vec()) begin errors++; $display("FAIL abort_cycle: dut=%h model=%h", a, model_vec()); end
        model_advance(1'b0, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        for (cyc = 0; cyc < 3; cyc++) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL abort_after cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            model_advance(1'b0, 1'b0);
            @(posedge clk); #1;
        end
        checks++;
        if (stall_count == 32'd0) begin errors++; $display("FAIL abort_stall_kept: got 0 want nonzero"); end
        out_ready = 1'b1;
        do_start(2'b01, 2'b00, 3, 0, 2, 0);
        first_sym = out_data;
        checks++;
        if (first_sym !== 2'b11) begin errors++; $display("FAIL abort_restart_seed: got %b want 11", first_sym); end
        cyc = 0;
        while ((m_run || m_done) && cyc < 30) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL abort_restart cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            model_advance(1'b1, 1'b0);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_ignored_start();
        int cyc, nacc; logic [52:0] a; bit rdy;
        do_start(2'b00, 2'b01, 3, 1, 2, 0);
        cyc = 0; nacc = 0;
        while ((m_run || m_done) && cyc < 100) begin
            rdy = ($urandom_range(0, 2) != 0);
            out_ready = rdy;
            start = (cyc == 2);
            if (cyc == 2) begin cfg_burst_len = 16'd7; cfg_mode = 2'b10; cfg_pattern = 2'b11; end
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL ignstart cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            if (out_valid && rdy) nacc++;
            model_advance(rdy, 1'b0);
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        checks++;
        if (nacc != 6) begin errors++; $display("FAIL ignstart_beats: got %0d want 6", nacc); end
        start = 1'b1; abort = 1'b1;
        model_advance(1'b1, 1'b1);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (cyc = 0; cyc < 3; cyc++) begin
            a = dut_vec(); checks++;
            if (a !== model_vec()) begin errors++; $display("FAIL start_abort_idle cyc %0d: dut=%h model=%h", cyc, a, model_vec()); end
            model_advance(1'b1, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int cyc, p; logic [52:0] a; bit rdy;
        for (int r = 0; r < 5; r++) begin
            p = $urandom_range(1, 4);
            do_start(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 5),
                     $urandom_range(0, 3), $urandom_range(1, 4), 0);
            cyc = 0;
            while ((m_run || m_done) && cyc < 400) begin
                rdy = ($urandom_range(0, 3) < p);
                out_ready = rdy;
                a = dut_vec(); checks++;
                if (a !== model_vec()) begin errors++; $display("FAIL random run %0d cyc %0d: dut=%h model=%h", r, cyc, a, model_vec()); end
                model_advance(rdy, 1'b0);
                @(posedge clk); #1; cyc++;
            end
            checks++;
            if (cyc >= 400) begin errors++; $display("FAIL random_timeout run %0d: cycles=%0d limit=400", r, cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_prbs();
        test_counter_stall();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
